vga_scanout: RTL and testbench
==============================

VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 SHALL have parameter H_VIS, 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, 16; H_SYNC, 96; H_BP, 48 (line total 800 clocks).
REQ-003 SHALL have parameter V_VIS, 480; V_FP, 10; V_SYNC, 2; V_BP, 33 (frame total 525 lines).
REQ-004 SHALL have port clk, input, 1: single pixel clock; all logic on its rising edge.
REQ-005 SHALL have port resetn, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port scan_en, input, 1: 1 = run timing; 0 = hold idle.
REQ-007 SHALL have port fb_addr, output, 15: framebuffer read address, 160x120 array, 9-bit pixels.
REQ-008 SHALL have port fb_rdata, input, 9: framebuffer data, valid exactly one clock after fb_addr (synchronous RAM); {R[8:6],G[5:3],B[2:0]}.
REQ-009 SHALL have port vga_r, vga_g, vga_b, output, 8 each: pixel colour.
REQ-010 SHALL have port vga_hs, vga_vs, output, 1 each: syncs, active-low.
REQ-011 SHALL have port vga_blank_n, output, 1: 1 = visible pixel.
REQ-012 SHALL have port vblank_pulse, output, 1: one-clock pulse at start of vertical blanking.

Function
REQ-013 SHALL keep hcount 0..799 incrementing every clock while scan_en=1, wrapping 799->0.
REQ-014 SHALL increment vcount 0..524 only on the hcount 799->0 wrap; at vcount=524 on that wrap, go to 0.
REQ-015 SHALL, when scan_en=0, clear both counters to 0 on the next clock and hold them there.
REQ-016 SHALL treat stage-0 visible as hcount<640 and vcount<480.
REQ-017 SHALL treat stage-0 hsync active as 656<=hcount<=751.
REQ-018 SHALL treat stage-0 vsync active as 490<=vcount<=491.
REQ-019 SHALL drive fb_addr combinationally from the counters: (vcount>>2)*160 + (hcount>>2), computed as row*128 + row*32 + col with no multiplier.
REQ-020 SHALL hold fb_addr at 0 when stage-0 visible is 0 or scan_en=0.
REQ-021 SHALL delay visible, hsync and vsync through two register stages.
REQ-022 SHALL make all outputs at cycle t+2 correspond to counter state at cycle t, so colour and syncs stay aligned.
REQ-023 SHALL register colour at stage 2 from fb_rdata, expanding each 3-bit field c to 8 bits as {c,c,c[2:1]}.
REQ-024 SHALL force vga_r/g/b=0 when the delayed visible flag is 0.
REQ-025 SHALL drive vga_hs = ~delayed_hsync, vga_vs = ~delayed_vsync and vga_blank_n = delayed_visible.
REQ-026 SHALL assert vblank_pulse, registered, for exactly one clock in the cycle after counters equal (0,480), once per frame.
REQ-027 SHALL, when scan_en falls mid-frame, flush the two pipeline stages naturally: outputs return to idle values within 2 clocks and no partial sync pulse is extended.
REQ-028 SHALL, when scan_en rises, restart timing at (0,0), with the first visible pixel at the outputs 2 clocks later.

Reset
REQ-029 SHALL, while resetn=0, force immediately hcount=0, vcount=0, all pipeline flags=0, vga_r/g/b=0, vga_hs=1, vga_vs=1, vga_blank_n=0, vblank_pulse=0.
REQ-030 SHALL restart at (0,0) after resetn deasserts mid-frame, with no residual sync or colour from before reset.

Verification
REQ-031 SHALL cover: reset released, scan_en=1 -> vga_hs low for exactly 96 clocks per 800-clock line; vga_vs low for exactly 2 lines (1600 clocks) per 420000-clock frame.
REQ-032 SHALL cover: RAM model returning addr[8:0] one clock late -> at counters (4,0), (639,479) and (8,4): fb_addr = 1, 19199, 162; outputs 2 clocks later show the matching expanded colour.
REQ-033 SHALL cover: fb_rdata=9'b111_010_001 at a visible pixel -> vga_r=0xFF, vga_g=0x49, vga_b=0x24; same data during blanking -> all 0, vga_blank_n=0.
REQ-034 SHALL cover: counters at (799,524) -> next clock (0,0); vblank_pulse high for exactly 1 clock per frame, 480*800+1 clocks after frame start.
REQ-035 SHALL cover: scan_en dropped during a sync pulse -> within 2 clocks vga_hs=1, vga_vs=1, vga_blank_n=0, fb_addr=0; re-enable -> first vga_blank_n=1 exactly 2 clocks later.
REQ-036 SHALL cover: resetn pulsed low asynchronously mid-line (between clock edges) -> outputs reach reset values before the next clock edge; timing resumes from (0,0).

Source files
------------

// File: rtl/vga_scanout.sv
// vga_scanout: VGA timing generator with framebuffer scan-out.
//
// Two free-running counters (hcount, vcount) define the raster. The counter
// state addresses a 160x120 framebuffer of 9-bit pixels held in a synchronous
// RAM (data returns one clock after the address). Visible/sync flags travel
// through two register stages so that colour, syncs and blanking leave the
// block together, two clocks after the counter state that produced them.
//
// Ports:
//   clk          pixel clock, rising edge
//   resetn       asynchronous active-low reset
//   scan_en      1 = run timing, 0 = counters cleared and held, outputs idle
//   fb_addr      framebuffer read address (row*160 + col, 0 when not visible)
//   fb_rdata     framebuffer pixel {R[8:6],G[5:3],B[2:0]}, one clock after fb_addr
//   vga_r/g/b    8-bit colour, zero outside the visible area
//   vga_hs/vs    active-low syncs
//   vga_blank_n  1 during visible pixels
//   vblank_pulse one-clock pulse at the start of vertical blanking
module vga_scanout #(
  parameter int unsigned H_VIS  = 640,
  parameter int unsigned H_FP   = 16,
  parameter int unsigned H_SYNC = 96,
  parameter int unsigned H_BP   = 48,
  parameter int unsigned V_VIS  = 480,
  parameter int unsigned V_FP   = 10,
  parameter int unsigned V_SYNC = 2,
  parameter int unsigned V_BP   = 33
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        scan_en,
  output logic [14:0] fb_addr,
  input  logic [8:0]  fb_rdata,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        vblank_pulse
);

  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW = $clog2(H_TOTAL);
  localparam int unsigned VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS_C  = HW'(H_VIS);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS_C  = VW'(V_VIS);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_VIS + V_FP + V_SYNC - 1);

  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;

  // stage 0 (combinational from counters)
  logic        vis0, hs0, vs0, vbl0;
  logic [14:0] row, col, addr_raw;

  // stage 1 and stage 2 registers
  logic       vis1, hs1, vs1;
  logic       vis2, hs2, vs2;
  logic [7:0] r2, g2, b2;

  function automatic logic [7:0] expand3(input logic [2:0] c);
    return {c, c, c[2:1]};
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hcount <= '0;
      vcount <= '0;
    end else if (!scan_en) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == H_LAST) begin
      hcount <= '0;
      vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
    end else begin
      hcount <= hcount + 1'b1;
    end
  end

  // Flags are gated by scan_en so that dropping it feeds idle values into
  // the pipeline at once; the two stages then drain without stretching syncs.
  always_comb begin
    vis0 = scan_en && (hcount < H_VIS_C) && (vcount < V_VIS_C);
    hs0  = scan_en && (hcount >= HS_FIRST) && (hcount <= HS_LAST);
    vs0  = scan_en && (vcount >= VS_FIRST) && (vcount <= VS_LAST);
    vbl0 = scan_en && (hcount == '0) && (vcount == V_VIS_C);
  end

  // row*160 + col as row*128 + row*32 + col
  always_comb begin
    row      = 15'(vcount >> 2);
    col      = 15'(hcount >> 2);
    addr_raw = (row << 7) + (row << 5) + col;
    fb_addr  = vis0 ? addr_raw : '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vis1         <= 1'b0;
      hs1          <= 1'b0;
      vs1          <= 1'b0;
      vis2         <= 1'b0;
      hs2          <= 1'b0;
      vs2          <= 1'b0;
      r2           <= '0;
      g2           <= '0;
      b2           <= '0;
      vblank_pulse <= 1'b0;
    end else begin
      vis1         <= vis0;
      hs1          <= hs0;
      vs1          <= vs0;
      vis2         <= vis1;
      hs2          <= hs1;
      vs2          <= vs1;
      // fb_rdata now belongs to the address issued alongside vis1
      r2           <= vis1 ? expand3(fb_rdata[8:6]) : '0;
      g2           <= vis1 ? expand3(fb_rdata[5:3]) : '0;
      b2           <= vis1 ? expand3(fb_rdata[2:0]) : '0;
      vblank_pulse <= vbl0;
    end
  end

  always_comb begin
    vga_r       = vis2 ? r2 : '0;
    vga_g       = vis2 ? g2 : '0;
    vga_b       = vis2 ? b2 : '0;
    vga_hs      = ~hs2;
    vga_vs      = ~vs2;
    vga_blank_n = vis2;
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout. A full-size instance checks line timing,
// addressing, colour expansion, scan_en drop/restart and async reset. A
// reduced-geometry instance (24x16 clock frame) checks frame-level behaviour
// (vsync, vblank_pulse, frame wrap, last visible pixel) in a short run.
// Sampling happens 1 time unit after each rising edge; "cyc" k means the
// counters hold state k (frame-relative index), fb_addr reflects state k,
// vblank_pulse reflects state k-1 and colour/sync outputs reflect state k-2.
module tb_vga_scanout;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic scan_en = 1'b0;
  logic force_col = 1'b0;

  logic [14:0] addr_b, addr_s;
  logic [8:0]  rdata_b = '0;
  logic [8:0]  rdata_s = '0;
  logic [7:0]  r_b, g_b, b_b, r_s, g_s, b_s;
  logic        hs_b, vs_b, bn_b, vp_b;
  logic        hs_s, vs_s, bn_s, vp_s;

  int cyc = 0;
  int nchk = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  // synchronous RAM models: data = address bits, one clock late
  always @(posedge clk) rdata_b <= force_col ? 9'h1D1 : addr_b[8:0];
  always @(posedge clk) rdata_s <= addr_s[8:0];

  vga_scanout u_big (
    .clk(clk), .resetn(resetn), .scan_en(scan_en),
    .fb_addr(addr_b), .fb_rdata(rdata_b),
    .vga_r(r_b), .vga_g(g_b), .vga_b(b_b),
    .vga_hs(hs_b), .vga_vs(vs_b), .vga_blank_n(bn_b), .vblank_pulse(vp_b)
  );

  vga_scanout #(
    .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_VIS(12), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_small (
    .clk(clk), .resetn(resetn), .scan_en(scan_en),
    .fb_addr(addr_s), .fb_rdata(rdata_s),
    .vga_r(r_s), .vga_g(g_s), .vga_b(b_s),
    .vga_hs(hs_s), .vga_vs(vs_s), .vga_blank_n(bn_s), .vblank_pulse(vp_s)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int k);
    while (cyc < k) tick();
  endtask

  // reset both instances, then enable scanning with counters at (0,0)
  task automatic restart();
    scan_en = 1'b0;
    resetn  = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
    scan_en = 1'b1;
    cyc = 0;
  endtask

  initial begin
    int n_hs, hs_first, hs_last;
    int n_vs, vs_first, vs_last, n_hs_s, n_vp, vp_first;

    // reset values
    tick();
    tick();
    chk("rst_blank_n", int'(bn_b), 0);
    chk("rst_hs", int'(hs_b), 1);
    chk("rst_vs", int'(vs_b), 1);
    chk("rst_rgb", int'({r_b, g_b, b_b}), 0);
    chk("rst_vblank", int'(vp_b), 0);
    chk("rst_addr", int'(addr_b), 0);
    chk("rst_small_sync", int'({hs_s, vs_s, bn_s, vp_s}), 4'b1100);

    // line timing and addressing, full geometry
    restart();
    chk("en_addr_00", int'(addr_b), 0);
    tick();
    chk("en_blank_c1", int'(bn_b), 0);
    tick();
    chk("en_blank_c2", int'(bn_b), 1);
    goto(4);
    chk("addr_4_0", int'(addr_b), 1);
    goto(6);
    chk("rgb_4_0", int'({r_b, g_b, b_b}), 24'h000024);
    n_hs = 0;
    hs_first = -1;
    hs_last = -1;
    while (cyc < 801) begin
      tick();
      if (!hs_b) begin
        n_hs++;
        if (hs_first < 0) hs_first = cyc;
        hs_last = cyc;
      end
    end
    chk("hs_low_count", n_hs, 96);
    chk("hs_first", hs_first, 658);
    chk("hs_last", hs_last, 753);
    goto(3208);
    chk("addr_8_4", int'(addr_b), 162);
    goto(3210);
    chk("rgb_8_4", int'({r_b, g_b, b_b}), 24'h499249);
    chk("blank_8_4", int'(bn_b), 1);

    // drop scan_en inside hsync (state h=700 of line 4)
    goto(3900);
    chk("hs_before_drop", int'(hs_b), 0);
    scan_en = 1'b0;
    goto(3902);
    chk("drop_hs", int'(hs_b), 1);
    chk("drop_vs", int'(vs_b), 1);
    chk("drop_blank", int'(bn_b), 0);
    chk("drop_addr", int'(addr_b), 0);
    goto(3905);
    chk("idle_blank", int'(bn_b), 0);
    scan_en = 1'b1;
    tick();
    chk("reen_c1_blank", int'(bn_b), 0);
    tick();
    chk("reen_c2_blank", int'(bn_b), 1);
    goto(3909);
    chk("reen_addr_4_0", int'(addr_b), 1);

    // asynchronous reset in the middle of a visible line
    goto(4005);
    chk("pre_rst_blank", int'(bn_b), 1);
    #3;
    resetn = 1'b0;
    #1;
    chk("arst_blank", int'(bn_b), 0);
    chk("arst_rgb", int'({r_b, g_b, b_b}), 0);
    chk("arst_syncs", int'({hs_b, vs_b, vp_b}), 3'b110);
    chk("arst_addr", int'(addr_b), 0);
    tick();
    resetn = 1'b1;
    cyc = 0;
    goto(2);
    chk("post_rst_blank", int'(bn_b), 1);
    chk("post_rst_rgb", int'({r_b, g_b, b_b}), 0);
    goto(4);
    chk("post_rst_addr", int'(addr_b), 1);
    goto(6);
    chk("post_rst_rgb_4_0", int'({r_b, g_b, b_b}), 24'h000024);

    // colour expansion with fixed RAM data 111_010_001
    force_col = 1'b1;
    restart();
    goto(7);
    chk("fix_rgb_vis", int'({r_b, g_b, b_b}), 24'hFF4924);
    chk("fix_blank_vis", int'(bn_b), 1);
    goto(640);
    chk("fix_addr_blank", int'(addr_b), 0);
    goto(642);
    chk("fix_rgb_blank", int'({r_b, g_b, b_b}), 0);
    chk("fix_blank_blank", int'(bn_b), 0);
    force_col = 1'b0;

    // frame-level timing, reduced geometry: 24 clocks/line, 16 lines/frame
    restart();
    n_vs = 0;
    vs_first = -1;
    vs_last = -1;
    n_hs_s = 0;
    n_vp = 0;
    vp_first = -1;
    while (cyc < 770) begin
      tick();
      if (cyc >= 2 && cyc <= 385) begin
        if (!vs_s) begin
          n_vs++;
          if (vs_first < 0) vs_first = cyc;
          vs_last = cyc;
        end
        if (!hs_s) n_hs_s++;
      end
      if (cyc <= 768 && vp_s) begin
        n_vp++;
        if (vp_first < 0) vp_first = cyc;
      end
      if (cyc == 279) chk("s_addr_last_vis", int'(addr_s), 323);
      if (cyc == 281) chk("s_rgb_last_vis", int'({r_s, g_s, b_s}), 24'hB6006D);
      if (cyc == 282) chk("s_blank_after_last", int'(bn_s), 0);
      if (cyc == 384) chk("s_wrap_addr", int'(addr_s), 0);
      if (cyc == 385) chk("s_wrap_blank_prev", int'(bn_s), 0);
      if (cyc == 386) chk("s_wrap_blank_first", int'(bn_s), 1);
      if (cyc == 388) chk("s_wrap_addr_4_0", int'(addr_s), 1);
    end
    chk("s_vs_low_count", n_vs, 48);
    chk("s_vs_first", vs_first, 314);
    chk("s_vs_last", vs_last, 361);
    chk("s_hs_low_frame", n_hs_s, 64);
    chk("s_vblank_count", n_vp, 2);
    chk("s_vblank_first", vp_first, 289);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
